// File: rtl/range_pkg.sv
// Shared types and sizing helpers for the range-finder stream driver.
package range_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PREP   = 3'd1,
        START  = 3'd2,
        STREAM = 3'd3,
        FINISH = 3'd4,
        WAIT   = 3'd5,
        DONE   = 3'd6
    } state_t;

    // Counter must hold the value DEPTH itself, hence one bit beyond the index width.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/range_sample_buffer.sv
// Sample register file: appends at the fill level, combinational read by index.
module range_sample_buffer
    import range_pkg::*;
#(
    parameter  int DW    = DATA_WIDTH,
    parameter  int DEPTH = 16,
    localparam int CW    = count_width(DEPTH),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [DW-1:0] rd_data,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic          do_write;

    // A write into a full buffer is dropped so stored samples are never overwritten.
    assign do_write = wr_en && (count != FULL);

    always_ff @(posedge clock) begin
        if (clear || flush) begin
            count <= '0;
        end else if (do_write) begin
            count <= count + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[count[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/range_stream_driver.sv
// Initiator for the range-finder stream: buffers samples, sequences one
// clear/start/beats/finish transaction and captures the returned range.
module range_stream_driver
    import range_pkg::*;
#(
    parameter  int DW      = DATA_WIDTH,
    parameter  int DEPTH   = 16,
    parameter  int TIMEOUT = 15,
    localparam int CW      = count_width(DEPTH),
    localparam int AW      = $clog2(DEPTH),
    localparam int WW      = $clog2(TIMEOUT + 1)
) (
    input  logic          clock,
    input  logic          clear,
    input  logic [DW-1:0] load_data,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic          go,
    input  logic          hold,
    output logic          rf_clear,
    output logic          start,
    output logic [DW-1:0] data_in,
    output logic          data_in_valid,
    output logic          finish,
    input  logic          range_valid,
    input  logic [DW-1:0] range_value,
    output logic [DW-1:0] result,
    output logic          result_valid,
    output logic          error,
    output logic          busy,
    output logic [CW-1:0] count,
    output logic [2:0]    state_dbg
);

    // Load handshake: a sample transfers on a rising edge where load_valid && load_ready.

    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] rd_ptr;
    logic [WW-1:0] wait_cnt;
    logic [DW-1:0] rd_data;
    logic          wr_en;
    logic          flush;
    logic          last_beat;
    logic          beat;

    assign wr_en     = load_valid && load_ready;
    assign flush     = (state == DONE);
    assign beat      = (state == STREAM) && !hold;
    assign last_beat = ({1'b0, rd_ptr} == (count - CW'(1)));

    range_sample_buffer #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_buf (
        .clock   (clock),
        .clear   (clear),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_data (load_data),
        .rd_idx  (rd_ptr),
        .rd_data (rd_data),
        .count   (count)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = PREP;
            PREP:    state_nxt = START;
            START:   state_nxt = (count != '0) ? STREAM : FINISH;
            STREAM:  if (!hold && last_beat) state_nxt = FINISH;
            FINISH:  state_nxt = WAIT;
            WAIT:    if (range_valid || (wait_cnt == WAIT_LAST)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers: read pointer, WAIT timeout counter, result and error.
    always_ff @(posedge clock) begin
        if (clear) begin
            rd_ptr   <= '0;
            wait_cnt <= '0;
            result   <= '0;
            error    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        result <= '0;
                        error  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (!hold) rd_ptr <= rd_ptr + AW'(1);
                end
                WAIT: begin
                    if (range_valid) begin
                        result <= range_value;
                    end else if (wait_cnt == WAIT_LAST) begin
                        error  <= 1'b1;
                        result <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                DONE: begin
                    rd_ptr   <= '0;
                    wait_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        load_ready    = (state == IDLE) && (count != FULL) && !go;
        rf_clear      = (state == PREP);
        start         = (state == START);
        data_in_valid = beat;
        data_in       = beat ? rd_data : '0;
        finish        = (state == FINISH);
        result_valid  = (state == DONE);
        busy          = (state != IDLE);
        state_dbg     = state;
    end

endmodule

// File: tb/tb_range_stream_driver.sv
// Directed bench for range_stream_driver, paired with a behavioural max-minus-min range finder.
module tb_range_stream_driver;

    logic        clock;
    logic        clear;
    logic [15:0] load_data;
    logic        load_valid;
    logic        load_ready;
    logic        go;
    logic        hold;
    logic        rf_clear;
    logic        start;
    logic [15:0] data_in;
    logic        data_in_valid;
    logic        finish;
    logic        range_valid;
    logic [15:0] range_value;
    logic [15:0] result;
    logic        result_valid;
    logic        error;
    logic        busy;
    logic [4:0]  count;
    logic [2:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    range_stream_driver dut (
        .clock         (clock),
        .clear         (clear),
        .load_data     (load_data),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .go            (go),
        .hold          (hold),
        .rf_clear      (rf_clear),
        .start         (start),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .finish        (finish),
        .range_valid   (range_valid),
        .range_value   (range_value),
        .result        (result),
        .result_valid  (result_valid),
        .error         (error),
        .busy          (busy),
        .count         (count),
        .state_dbg     (state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // behavioural range finder: range = max - min over the beats since its last reset
    logic [15:0] rf_max, rf_min, rf_val;
    logic        rf_rv;
    logic        rf_en;

    always @(posedge clock) begin
        if (clear || rf_clear) begin
            rf_max <= 16'h0000;
            rf_min <= 16'hFFFF;
            rf_rv  <= 1'b0;
            rf_val <= 16'h0000;
        end else begin
            rf_rv <= finish;
            if (finish) rf_val <= rf_max - rf_min;
            if (data_in_valid) begin
                if (data_in > rf_max) rf_max <= data_in;
                if (data_in < rf_min) rf_min <= data_in;
            end
        end
    end

    assign range_valid = rf_en ? rf_rv : 1'b0;
    assign range_value = rf_val;

    // scoreboard
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    logic [4:0]  trace [0:63];
    logic [15:0] res_at_done;
    logic        err_at_done;
    int          hold_beats;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [15:0] v);
        load_data  = v;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic check_beats(input string tag);
        check({tag, "_nbeats"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check({tag, "_beat"}, obs_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        obs_q.delete();
    endtask

    // go is sampled at the first edge; cycle k is the k-th cycle after that edge
    task automatic run(input bit toggle_hold, input int bound, output int done_cyc);
        for (int i = 0; i < 64; i++) trace[i] = 5'b0;
        obs_q.delete();
        hold_beats = 0;
        done_cyc   = -1;
        go = 1'b1;
        tick();
        go         = 1'b0;
        load_valid = 1'b0;
        for (int k = 1; k <= bound; k++) begin
            hold = toggle_hold ? k[0] : 1'b0;
            #4;
            trace[k] = {rf_clear, start, data_in_valid, finish, result_valid};
            if (data_in_valid) obs_q.push_back(data_in);
            if (data_in_valid && hold) hold_beats++;
            if (result_valid) begin
                done_cyc    = k;
                res_at_done = result;
                err_at_done = error;
            end
            tick();
            if (done_cyc >= 0) break;
        end
        hold = 1'b0;
        if (done_cyc < 0) check("run_timeout", 32'd0, 32'd1);
    endtask

    int done;

    initial begin
        clear = 1'b1; load_data = '0; load_valid = 1'b0; go = 1'b0; hold = 1'b0; rf_en = 1'b1;
        tick(); tick();
        clear = 1'b0;
        #4;
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_load_ready", load_ready, 1);
        check("rst_result", result, 0);
        check("rst_error", error, 0);
        check("rst_protocol", {rf_clear, start, data_in_valid, finish, result_valid}, 0);
        check("rst_data_in", data_in, 0);
        tick();

        // 1: three samples, no hold
        load(16'h0003); load(16'h0007); load(16'h0005);
        check("t1_count", count, 3);
        exp_q.push_back(16'h0003); exp_q.push_back(16'h0007); exp_q.push_back(16'h0005);
        run(1'b0, 40, done);
        check("t1_c1_rf_clear", trace[1], 5'b10000);
        check("t1_c2_start", trace[2], 5'b01000);
        check("t1_c3_beat", trace[3], 5'b00100);
        check("t1_c4_beat", trace[4], 5'b00100);
        check("t1_c5_beat", trace[5], 5'b00100);
        check("t1_c6_finish", trace[6], 5'b00010);
        check("t1_c7_wait", trace[7], 5'b00000);
        check("t1_done_cycle", done, 8);
        check("t1_result", res_at_done, 16'h0004);
        check("t1_error", err_at_done, 0);
        check_beats("t1");
        check("t1_count_after", count, 0);
        check("t1_result_held", result, 16'h0004);

        // 2: hold toggles every cycle
        load(16'hFFFF); load(16'h0000);
        exp_q.push_back(16'hFFFF); exp_q.push_back(16'h0000);
        run(1'b1, 40, done);
        check("t2_hold_beats", hold_beats, 0);
        check("t2_c3_hold", trace[3], 5'b00000);
        check("t2_c4_beat", trace[4], 5'b00100);
        check("t2_done_cycle", done, 9);
        check("t2_result", res_at_done, 16'hFFFF);
        check_beats("t2");

        // 3: fill the buffer, 17th load refused
        for (int i = 0; i < 16; i++) begin
            check("t3_ready", load_ready, 1);
            load(16'h0010 + 16'(i));
            exp_q.push_back(16'h0010 + 16'(i));
        end
        load_data = 16'hDEAD; load_valid = 1'b1;
        #1;
        check("t3_ready_full", load_ready, 0);
        tick();
        load_valid = 1'b0;
        check("t3_count_full", count, 16);
        run(1'b0, 60, done);
        check("t3_done_cycle", done, 21);
        check("t3_result", res_at_done, 16'h000F);
        check_beats("t3");

        // 4: empty run; a load presented together with go is dropped
        load_data = 16'h0099; load_valid = 1'b1;
        run(1'b0, 40, done);
        check("t4_c2_start", trace[2], 5'b01000);
        check("t4_c3_finish", trace[3], 5'b00010);
        check("t4_done_cycle", done, 5);
        check("t4_result", res_at_done, 16'h0001);
        check_beats("t4");
        check("t4_count", count, 0);

        // 5: no range finder answer -> timeout
        rf_en = 1'b0;
        run(1'b0, 40, done);
        check("t5_done_cycle", done, 19);
        check("t5_error", err_at_done, 1);
        check("t5_result", res_at_done, 0);
        check("t5_error_held", error, 1);
        rf_en = 1'b1;

        // 6: clear during the second beat, then a one-sample run
        load(16'h0011); load(16'h0022); load(16'h0033);
        go = 1'b1;
        tick();
        go = 1'b0;
        tick(); tick(); tick();
        check("t6_in_stream", data_in_valid, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #4;
        check("t6_busy", busy, 0);
        check("t6_count", count, 0);
        check("t6_protocol", {rf_clear, start, data_in_valid, finish, result_valid}, 0);
        check("t6_error", error, 0);
        tick();
        load(16'h0042);
        exp_q.push_back(16'h0042);
        run(1'b0, 40, done);
        check("t6_done_cycle", done, 6);
        check("t6_result", res_at_done, 16'h0000);
        check("t6_error_after", err_at_done, 0);
        check_beats("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
